// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: issues PC reads to a synchronous memory, tags returned words
// with their PC and queues them for decode. Optional counters under FETCH_PERF_EN.
module if_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              branch_true,
  output logic              pc_hold,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              push;
  logic              pop;

  // Hold ignores a same-cycle pop so a push can never land on a full queue.
  assign occupancy  = {1'b0, count} + OCC_W'(vld_p1);
  assign pc_hold    = !rst && (occupancy >= DEPTH_OCC);
  assign issue      = !rst && !pc_hold && !branch_true;
  assign imem_en    = issue;
  assign imem_addr  = rst ? '0 : pc_in;

  assign push       = vld_p1 && !branch_true;
  assign inst_valid = (count != '0) && !branch_true;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

  // Stage p0 -> p1: address issued, word returns from memory during p1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_true) begin
      vld_p1 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      vld_p1 <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1 -> queue: tag the returning word with the PC that fetched it.
  always_ff @(posedge clk) begin
    pc_p1 <= pc_in;
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= pc_p1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)        perf_fetched <= perf_fetched + 32'd1;
      if (branch_true) perf_flushed <= perf_flushed + 32'(occupancy);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: queue-level reference model checked every cycle,
// plus hand-computed literal expectations. Perf ports exercised when FETCH_PERF_EN is defined.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        branch_true;
  logic        pc_hold;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .branch_true(branch_true),
    .pc_hold(pc_hold), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word = address + 0x100, one cycle after the strobe.
  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr + 32'h100;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of tagged words plus one outstanding read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;
  ent_t        q[$];
  int          infl_v = 0;
  logic [31:0] infl_pc = '0;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_flushed = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      infl_v    = 0;
      m_fetched = '0;
      m_flushed = '0;
    end else if (branch_true) begin
      m_flushed = m_flushed + 32'(q.size() + infl_v);
      q.delete();
      infl_v = 0;
    end else begin
      bit hold;
      ent_t e;
      hold = (q.size() + infl_v) >= DEPTH;
      if (q.size() != 0 && inst_ready) void'(q.pop_front());
      if (infl_v != 0) begin
        e.pc   = infl_pc;
        e.data = infl_pc + 32'h100;
        q.push_back(e);
        m_fetched = m_fetched + 32'd1;
      end
      infl_v  = hold ? 0 : 1;
      infl_pc = pc_in;
    end
  end

  // Compare process: every cycle, mid low phase, after inputs have settled.
  always begin
    bit exp_hold, exp_valid, exp_en;
    @(negedge clk);
    #3;
    exp_hold  = !rst && ((q.size() + infl_v) >= DEPTH);
    exp_valid = !rst && (q.size() != 0) && !branch_true;
    exp_en    = !rst && !exp_hold && !branch_true;
    chk("pc_hold",    32'(pc_hold),    32'(exp_hold));
    chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
    chk("imem_en",    32'(imem_en),    32'(exp_en));
    chk("imem_addr",  imem_addr,       rst ? 32'h0 : pc_in);
    if (exp_valid) begin
      chk("inst_pc",   inst_pc,   q[0].pc);
      chk("inst_data", inst_data, q[0].data);
    end else if (rst) begin
      chk("inst_pc_rst",   inst_pc,   32'h0);
      chk("inst_data_rst", inst_data, 32'h0);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
  end

  // PC source: advances only after a cycle that actually issued, redirects after a branch.
  logic [31:0] pc;
  bit          adv;
  bit          redir;
  logic [31:0] redir_tgt;

  task automatic start_stream(input logic [31:0] p);
    pc = p; adv = 0; redir = 0; redir_tgt = '0;
  endtask

  // Called on a negedge; returns on the following negedge.
  task automatic tick(input bit br, input bit rdy, input logic [31:0] tgt);
    if (redir) pc = redir_tgt;
    else if (adv) pc = pc + 32'd1;
    pc_in       = pc;
    branch_true = br;
    inst_ready  = rdy;
    #1;
    adv       = !pc_hold && !br;
    redir     = br;
    redir_tgt = tgt;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b1; pc_in = 32'h55; branch_true = 1'b0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_imem_addr",  imem_addr,        32'h0);
    chk("rst_imem_en",    32'(imem_en),     32'h0);
    chk("rst_inst_valid", 32'(inst_valid),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    start_stream(start_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_in = '0; branch_true = 1'b0; inst_ready = 1'b0;
    @(negedge clk);

    // Basic stream: first valid at cycle 2, words in PC order.
    do_reset(32'h0);
    tick(0, 1, 0);
    chk("t1_valid_c1", 32'(inst_valid), 32'h0);
    tick(0, 1, 0);
    chk("t1_valid_c2", 32'(inst_valid), 32'h1);
    chk("t1_pc_c2",    inst_pc,         32'h0);
    chk("t1_data_c2",  inst_data,       32'h100);
    tick(0, 1, 0);
    chk("t1_pc_c3",    inst_pc,         32'h1);
    chk("t1_data_c3",  inst_data,       32'h101);
    repeat (6) tick(0, 1, 0);

    // Backpressure: hold once 3 queued + 1 in flight, exactly 4 entries kept.
    do_reset(32'h0);
    repeat (4) tick(0, 0, 0);
    chk("t2_hold_c4", 32'(pc_hold), 32'h1);
    repeat (2) tick(0, 0, 0);
    chk("t2_hold_c6", 32'(pc_hold), 32'h1);
    chk("t2_head_c6", inst_pc,      32'h0);
    tick(0, 1, 0);
    chk("t2_head_c7", inst_pc,      32'h1);

    // Sustained traffic through a near-full queue: many pointer wraps.
    for (int i = 0; i < 48; i++) tick(0, (i % 3) != 2, 0);
    repeat (6) tick(0, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0);

    // Flush with 3 queued + 1 in flight, redirect to 0x40.
    do_reset(32'h0);
    repeat (4) tick(0, 0, 0);
    chk("t3_hold_pre", 32'(pc_hold), 32'h1);
    branch_true = 1'b1;
    #1;
    chk("t3_valid_br", 32'(inst_valid), 32'h0);
    chk("t3_en_br",    32'(imem_en),    32'h0);
    tick(1, 0, 32'h40);
    chk("t3_valid_post", 32'(inst_valid), 32'h0);
    chk("t3_hold_post",  32'(pc_hold),    32'h0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    chk("t3_valid_tgt", 32'(inst_valid), 32'h1);
    chk("t3_pc_tgt",    inst_pc,         32'h40);
    chk("t3_data_tgt",  inst_data,       32'h140);
    repeat (4) tick(0, 1, 0);

    // Asynchronous reset with 2 entries queued, restart at 0x200.
    do_reset(32'h0);
    repeat (3) tick(0, 0, 0);
    chk("t5_valid_pre", 32'(inst_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_valid_rst", 32'(inst_valid), 32'h0);
    chk("t5_hold_rst",  32'(pc_hold),    32'h0);
    chk("t5_en_rst",    32'(imem_en),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    start_stream(32'h200);
    tick(0, 1, 0);
    tick(0, 1, 0);
    chk("t5_valid_restart", 32'(inst_valid), 32'h1);
    chk("t5_pc_restart",    inst_pc,         32'h200);
    chk("t5_data_restart",  inst_data,       32'h300);

    // 10 pushes, then flush with 2 queued + 1 in flight.
    do_reset(32'h0);
    repeat (10) tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 32'h80);
`ifdef FETCH_PERF_EN
    chk("t6_perf_fetched", perf_fetched, 32'd10);
    chk("t6_perf_flushed", perf_flushed, 32'd3);
`endif
    repeat (4) tick(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
